// File: rtl/uart_pkg.sv
// Shared definitions for the UART receiver / display front end.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } uart_state_t;

   localparam int unsigned DATA_BITS        = 8;
   localparam int unsigned CLKS_PER_BIT_DEF = 10416;

endpackage

// File: rtl/rx_sync_edge.sv
// Two-flop synchronizer for the raw RX pin plus falling-edge detection.
module rx_sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic rx,
   output logic rx_s,
   output logic rx_fall
);

   logic rx_meta;
   logic rx_prev;

   // All flops reset high so an idle line never looks like a start edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   assign rx_fall = rx_prev & ~rx_s;

endmodule

// File: rtl/uart_rx_disp.sv
// UART 8N1 receiver that shifts each good byte into a 16-bit display word.
module uart_rx_disp
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter logic [15:0] DISP_RST     = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rx,
   output logic [7:0]  rx_byte,
   output logic        rx_valid,
   output logic        frame_err,
   output logic        busy,
   output logic [15:0] disp_data
);

   localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

   logic rx_s;
   logic rx_fall;

   rx_sync_edge u_sync (
      .clk     (clk),
      .rst     (rst),
      .rx      (rx),
      .rx_s    (rx_s),
      .rx_fall (rx_fall)
   );

   uart_state_t          state, state_nxt;
   logic [CNT_W-1:0]     cnt, cnt_nxt;
   logic [2:0]           bit_idx, bit_idx_nxt;
   logic [DATA_BITS-1:0] shreg, shreg_nxt;
   logic [7:0]           rx_byte_nxt;
   logic [15:0]          disp_nxt;
   logic                 valid_nxt, ferr_nxt, busy_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         rx_byte   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
         busy      <= 1'b0;
         disp_data <= DISP_RST;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         bit_idx   <= bit_idx_nxt;
         shreg     <= shreg_nxt;
         rx_byte   <= rx_byte_nxt;
         rx_valid  <= valid_nxt;
         frame_err <= ferr_nxt;
         busy      <= busy_nxt;
         disp_data <= disp_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      bit_idx_nxt = bit_idx;
      shreg_nxt   = shreg;
      rx_byte_nxt = rx_byte;
      disp_nxt    = disp_data;
      valid_nxt   = 1'b0;
      ferr_nxt    = 1'b0;

      case (state)
         IDLE: begin
            cnt_nxt = '0;
            if (rx_fall) state_nxt = START;
         end
         START: begin
            // Half-bit wait puts every later sample near the bit centre.
            if (cnt == HALF_LAST) begin
               cnt_nxt = '0;
               if (rx_s) begin
                  state_nxt = IDLE;
               end else begin
                  state_nxt   = DATA;
                  bit_idx_nxt = '0;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         DATA: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt            = '0;
               shreg_nxt[bit_idx] = rx_s;
               if (bit_idx == IDX_LAST) state_nxt   = STOP;
               else                     bit_idx_nxt = bit_idx + 3'd1;
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         STOP: begin
            if (cnt == BIT_LAST) begin
               cnt_nxt   = '0;
               state_nxt = IDLE;
               if (rx_s) begin
                  valid_nxt   = 1'b1;
                  rx_byte_nxt = shreg;
                  disp_nxt    = {disp_data[7:0], shreg};
               end else begin
                  ferr_nxt = 1'b1;
               end
            end else begin
               cnt_nxt = cnt + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase

      busy_nxt = (state_nxt != IDLE);
   end

endmodule

// File: tb/tb_uart_rx_disp.sv
// Scoreboard bench: expected frame results are queued by the driver and popped by the monitor.
module tb_uart_rx_disp;

   localparam int unsigned CPB = 16;

   logic        clk;
   logic        rst;
   logic        rx;
   logic [7:0]  rx_byte;
   logic        rx_valid;
   logic        frame_err;
   logic        busy;
   logic [15:0] disp_data;

   uart_rx_disp #(.CLKS_PER_BIT(CPB), .DISP_RST(16'hFFFF)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx        (rx),
      .rx_byte   (rx_byte),
      .rx_valid  (rx_valid),
      .frame_err (frame_err),
      .busy      (busy),
      .disp_data (disp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic        ferr;
      logic [7:0]  b;
      logic [15:0] d;
   } exp_t;

   exp_t        sb[$];
   int          checks   = 0;
   int          failures = 0;
   logic [15:0] exp_disp = 16'hFFFF;
   logic [7:0]  exp_byte = 8'h00;

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every output pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst && (rx_valid || frame_err)) begin
         exp_t e;
         chk("pulse_exclusive", {15'd0, rx_valid & frame_err}, 16'd0);
         if (sb.size() == 0) begin
            chk("unexpected_pulse", {14'd0, rx_valid, frame_err}, 16'd0);
         end else begin
            e = sb.pop_front();
            chk("pulse_kind", {15'd0, frame_err}, {15'd0, e.ferr});
            chk("rx_byte", {8'd0, rx_byte}, {8'd0, e.b});
            chk("disp_data", disp_data, e.d);
            chk("busy_at_end", {15'd0, busy}, 16'd0);
         end
      end
   end

   task automatic hold(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop);
      if (stop) begin
         exp_disp = {exp_disp[7:0], b};
         exp_byte = b;
         sb.push_back('{ferr: 1'b0, b: b, d: exp_disp});
      end else begin
         sb.push_back('{ferr: 1'b1, b: exp_byte, d: exp_disp});
      end
      hold(1'b0, CPB);
      for (int i = 0; i < 8; i++) hold(b[i], CPB);
      hold(stop, CPB);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_disp"},  disp_data, 16'hFFFF);
      chk({tag, "_byte"},  {8'd0, rx_byte}, 16'h0000);
      chk({tag, "_flags"}, {13'd0, rx_valid, frame_err, busy}, 16'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int busy_cnt;
      rst = 1'b0;
      rx  = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b1;
      hold(1'b1, 20);

      // Single byte
      send_frame(8'h5A, 1'b1);
      hold(1'b1, 20);
      chk("disp_5a", disp_data, 16'hFF5A);
      chk("busy_idle_5a", {15'd0, busy}, 16'd0);

      // Back-to-back bytes
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      hold(1'b1, 20);
      chk("disp_1234", disp_data, 16'h1234);
      send_frame(8'hAB, 1'b1);
      hold(1'b1, 20);
      chk("disp_34ab", disp_data, 16'h34AB);

      // False start: 4-cycle glitch
      busy_cnt = 0;
      rx = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      rx = 1'b1;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("false_start_busy_cycles", 16'(busy_cnt), 16'd8);
      chk("false_start_disp", disp_data, 16'h34AB);

      // Framing error then line held low
      send_frame(8'hA5, 1'b0);
      busy_cnt = 0;
      rx = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (busy) busy_cnt++;
      end
      chk("no_retrigger_busy", 16'(busy_cnt), 16'd0);
      chk("ferr_disp", disp_data, 16'h34AB);
      chk("ferr_byte", {8'd0, rx_byte}, 16'h00AB);
      hold(1'b1, CPB);
      send_frame(8'h0F, 1'b1);
      hold(1'b1, 20);
      chk("disp_0f", disp_data, 16'hAB0F);

      // Reset during data bit 3; no expectation is queued for the aborted frame
      hold(1'b0, CPB);
      hold(1'b1, CPB);
      hold(1'b1, CPB);
      hold(1'b0, CPB);
      hold(1'b1, CPB / 2);
      rst = 1'b0;
      #1;
      check_reset_outputs("midframe_reset");
      rx = 1'b1;
      repeat (5) @(negedge clk);
      check_reset_outputs("midframe_reset_hold");
      exp_disp = 16'hFFFF;
      exp_byte = 8'h00;
      rst = 1'b1;
      hold(1'b1, 20);
      send_frame(8'h3C, 1'b1);
      hold(1'b1, 20);
      chk("disp_3c", disp_data, 16'hFF3C);

      chk("scoreboard_drained", 16'(sb.size()), 16'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
